// File: rtl/fifo_ctrl_if.sv
// Handshake and status bundle between a FIFO user and its controller.
// The user side drives requests; the controller side returns enables, pointers and flags.
interface fifo_ctrl_if #(
    parameter int FIFO_ADDRESS_SIZE = 2
);
    logic                         wr_req;
    logic                         rd_req;
    logic                         clr_err;
    logic                         cw_en;
    logic                         cr_en;
    logic [FIFO_ADDRESS_SIZE:0]   w_ptr;
    logic [FIFO_ADDRESS_SIZE:0]   r_ptr;
    logic [FIFO_ADDRESS_SIZE:0]   count;
    logic                         full;
    logic                         empty;
    logic                         almost_full;
    logic                         almost_empty;
    logic                         rvalid;
    logic                         overflow;
    logic                         underflow;

    modport master (
        output wr_req, rd_req, clr_err,
        input  cw_en, cr_en, w_ptr, r_ptr, count,
        input  full, empty, almost_full, almost_empty,
        input  rvalid, overflow, underflow
    );

    modport slave (
        input  wr_req, rd_req, clr_err,
        output cw_en, cr_en, w_ptr, r_ptr, count,
        output full, empty, almost_full, almost_empty,
        output rvalid, overflow, underflow
    );
endinterface

// File: rtl/fifo_ctrl.sv
// Single-clock FIFO controller: pointer/occupancy state, accept logic,
// status flags, read-valid tracking and sticky overflow/underflow.
module fifo_ctrl #(
    parameter int MEMORY_DEPTH      = 4,
    parameter int FIFO_ADDRESS_SIZE = $clog2(MEMORY_DEPTH),
    parameter int AFULL_THRESH      = MEMORY_DEPTH - 1,
    parameter int AEMPTY_THRESH     = 1
) (
    input  logic      clk,
    input  logic      rst_n,
    fifo_ctrl_if.slave bus
);
    localparam int PW = FIFO_ADDRESS_SIZE + 1;
    localparam int AW = FIFO_ADDRESS_SIZE;

    typedef logic [PW-1:0] ptr_t;

    localparam ptr_t AF_T = ptr_t'(AFULL_THRESH);
    localparam ptr_t AE_T = ptr_t'(AEMPTY_THRESH);
    localparam ptr_t ONE  = ptr_t'(1);

    ptr_t w_ptr_q;
    ptr_t r_ptr_q;
    ptr_t count_q;
    logic rvalid_q;
    logic ovf_q;
    logic udf_q;

    logic full;
    logic empty;
    logic cw_en;
    logic cr_en;

    // Same address with opposite wrap bits means the writer is a lap ahead.
    assign empty = (w_ptr_q == r_ptr_q);
    assign full  = (w_ptr_q[AW] != r_ptr_q[AW]) &&
                   (w_ptr_q[AW-1:0] == r_ptr_q[AW-1:0]);

    assign cw_en = bus.wr_req & ~full;
    assign cr_en = bus.rd_req & ~empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_ptr_q  <= '0;
            r_ptr_q  <= '0;
            count_q  <= '0;
            rvalid_q <= 1'b0;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            if (cw_en) w_ptr_q <= w_ptr_q + ONE;
            if (cr_en) r_ptr_q <= r_ptr_q + ONE;
            unique case ({cw_en, cr_en})
                2'b10:   count_q <= count_q + ONE;
                2'b01:   count_q <= count_q - ONE;
                default: count_q <= count_q;
            endcase
            rvalid_q <= cr_en;
            // A new error in the clearing cycle must not be lost.
            ovf_q <= (ovf_q & ~bus.clr_err) | (bus.wr_req & full);
            udf_q <= (udf_q & ~bus.clr_err) | (bus.rd_req & empty);
        end
    end

    assign bus.cw_en        = cw_en;
    assign bus.cr_en        = cr_en;
    assign bus.w_ptr        = w_ptr_q;
    assign bus.r_ptr        = r_ptr_q;
    assign bus.count        = count_q;
    assign bus.full         = full;
    assign bus.empty        = empty;
    assign bus.almost_full  = (count_q >= AF_T);
    assign bus.almost_empty = (count_q <= AE_T);
    assign bus.rvalid       = rvalid_q;
    assign bus.overflow     = ovf_q;
    assign bus.underflow    = udf_q;
endmodule

// File: tb/tb_fifo_ctrl.sv
// Directed bench for fifo_ctrl with a behavioural 4x8 storage array
// so read order and read latency can be observed.
module tb_fifo_ctrl;
    logic clk;
    logic rst_n;
    logic [7:0] wdata;
    logic [7:0] rdata;
    logic [7:0] mem [4];
    int total;
    int fails;

    fifo_ctrl_if #(.FIFO_ADDRESS_SIZE(2)) bus ();

    fifo_ctrl #(.MEMORY_DEPTH(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Storage array: synchronous write, registered read port.
    always @(posedge clk) begin
        if (bus.cw_en) mem[bus.w_ptr[1:0]] <= wdata;
        if (bus.cr_en) rdata <= mem[bus.r_ptr[1:0]];
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_in(input logic w, input logic r, input logic c,
                          input logic [7:0] d);
        @(negedge clk);
        bus.wr_req  = w;
        bus.rd_req  = r;
        bus.clr_err = c;
        wdata       = d;
        #1;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        logic [2:0] diff;
        diff = bus.w_ptr - bus.r_ptr;
        if (rst_n) chk("count_inv", 32'(bus.count), 32'(diff));
    end

    initial begin
        total = 0;
        fails = 0;
        rst_n = 1'b0;
        bus.wr_req  = 1'b0;
        bus.rd_req  = 1'b0;
        bus.clr_err = 1'b0;
        wdata = 8'h00;
        #3;
        chk("rst_count", 32'(bus.count), 32'd0);
        chk("rst_wptr", 32'(bus.w_ptr), 32'd0);
        chk("rst_rptr", 32'(bus.r_ptr), 32'd0);
        chk("rst_empty", 32'(bus.empty), 32'd1);
        chk("rst_full", 32'(bus.full), 32'd0);
        chk("rst_aempty", 32'(bus.almost_empty), 32'd1);
        chk("rst_afull", 32'(bus.almost_full), 32'd0);
        chk("rst_cw_en", 32'(bus.cw_en), 32'd0);
        chk("rst_cr_en", 32'(bus.cr_en), 32'd0);
        chk("rst_rvalid", 32'(bus.rvalid), 32'd0);
        chk("rst_ovf", 32'(bus.overflow), 32'd0);
        chk("rst_udf", 32'(bus.underflow), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Fill with A..D
        for (int i = 0; i < 4; i++) begin
            set_in(1'b1, 1'b0, 1'b0, 8'(8'hA + i));
            chk("fill_cw_en", 32'(bus.cw_en), 32'd1);
            tick();
            chk("fill_count", 32'(bus.count), 32'(i + 1));
            chk("fill_afull", 32'(bus.almost_full), 32'(i >= 2));
        end
        chk("fill_full", 32'(bus.full), 32'd1);
        chk("fill_wptr", 32'(bus.w_ptr), 32'd4);
        chk("fill_rptr", 32'(bus.r_ptr), 32'd0);

        // Push into full FIFO
        set_in(1'b1, 1'b0, 1'b0, 8'hEE);
        chk("ovf_cw_en", 32'(bus.cw_en), 32'd0);
        tick();
        chk("ovf_wptr", 32'(bus.w_ptr), 32'd4);
        chk("ovf_set", 32'(bus.overflow), 32'd1);
        set_in(1'b0, 1'b0, 1'b0, 8'h00);
        tick();
        chk("ovf_sticky", 32'(bus.overflow), 32'd1);
        set_in(1'b0, 1'b0, 1'b1, 8'h00);
        tick();
        chk("ovf_clr", 32'(bus.overflow), 32'd0);

        // Drain A..D
        for (int i = 0; i < 4; i++) begin
            set_in(1'b0, 1'b1, 1'b0, 8'h00);
            chk("pop_cr_en", 32'(bus.cr_en), 32'd1);
            tick();
            chk("pop_rvalid", 32'(bus.rvalid), 32'd1);
            chk("pop_rdata", 32'(rdata), 32'(8'hA + i));
        end
        set_in(1'b0, 1'b0, 1'b0, 8'h00);
        tick();
        chk("drain_rvalid", 32'(bus.rvalid), 32'd0);
        chk("drain_empty", 32'(bus.empty), 32'd1);
        chk("drain_rptr", 32'(bus.r_ptr), 32'd4);

        // Simultaneous push/pop while empty, then while non-empty
        set_in(1'b1, 1'b1, 1'b0, 8'h05);
        chk("se_cw_en", 32'(bus.cw_en), 32'd1);
        chk("se_cr_en", 32'(bus.cr_en), 32'd0);
        tick();
        chk("se_udf", 32'(bus.underflow), 32'd1);
        chk("se_count", 32'(bus.count), 32'd1);
        chk("se_rvalid", 32'(bus.rvalid), 32'd0);
        set_in(1'b1, 1'b1, 1'b0, 8'h06);
        chk("sb_cw_en", 32'(bus.cw_en), 32'd1);
        chk("sb_cr_en", 32'(bus.cr_en), 32'd1);
        tick();
        chk("sb_count", 32'(bus.count), 32'd1);
        chk("sb_rvalid", 32'(bus.rvalid), 32'd1);
        chk("sb_rdata", 32'(rdata), 32'h05);

        // Clear, top up to full, then simultaneous push/pop while full
        set_in(1'b0, 1'b0, 1'b1, 8'h00);
        tick();
        chk("udf_clr", 32'(bus.underflow), 32'd0);
        for (int i = 0; i < 3; i++) begin
            set_in(1'b1, 1'b0, 1'b0, 8'(8'h7 + i));
            tick();
        end
        chk("top_full", 32'(bus.full), 32'd1);
        chk("top_wptr", 32'(bus.w_ptr), 32'd1);
        set_in(1'b1, 1'b1, 1'b0, 8'hFF);
        chk("sf_cw_en", 32'(bus.cw_en), 32'd0);
        chk("sf_cr_en", 32'(bus.cr_en), 32'd1);
        tick();
        chk("sf_count", 32'(bus.count), 32'd3);
        chk("sf_ovf", 32'(bus.overflow), 32'd1);
        chk("sf_rdata", 32'(rdata), 32'h06);

        // Drain 7,8,9 and clear errors
        for (int i = 0; i < 3; i++) begin
            set_in(1'b0, 1'b1, i == 0, 8'h00);
            tick();
            chk("d2_rdata", 32'(rdata), 32'(8'h7 + i));
        end
        chk("d2_empty", 32'(bus.empty), 32'd1);
        chk("d2_ovf", 32'(bus.overflow), 32'd0);
        chk("d2_rptr", 32'(bus.r_ptr), 32'd1);

        // Wrap: 10 push/pop pairs with random idle cycles
        for (int k = 0; k < 10; k++) begin
            set_in(1'b1, 1'b0, 1'b0, 8'(8'h10 + k));
            tick();
            repeat ($urandom_range(0, 2)) begin
                set_in(1'b0, 1'b0, 1'b0, 8'h00);
                tick();
            end
            set_in(1'b0, 1'b1, 1'b0, 8'h00);
            tick();
            chk("wrap_rvalid", 32'(bus.rvalid), 32'd1);
            chk("wrap_rdata", 32'(rdata), 32'(8'h10 + k));
            repeat ($urandom_range(0, 2)) begin
                set_in(1'b0, 1'b0, 1'b0, 8'h00);
                tick();
            end
        end
        chk("wrap_wptr", 32'(bus.w_ptr), 32'd3);
        chk("wrap_rptr", 32'(bus.r_ptr), 32'd3);
        chk("wrap_empty", 32'(bus.empty), 32'd1);
        chk("wrap_errs", 32'({bus.overflow, bus.underflow}), 32'd0);

        // Mid-operation async reset with count=2 and rvalid high
        for (int i = 0; i < 3; i++) begin
            set_in(1'b1, 1'b0, 1'b0, 8'(8'h30 + i));
            tick();
        end
        set_in(1'b0, 1'b1, 1'b0, 8'h00);
        tick();
        chk("pre_rst_count", 32'(bus.count), 32'd2);
        chk("pre_rst_rvalid", 32'(bus.rvalid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_count", 32'(bus.count), 32'd0);
        chk("arst_wptr", 32'(bus.w_ptr), 32'd0);
        chk("arst_rptr", 32'(bus.r_ptr), 32'd0);
        chk("arst_rvalid", 32'(bus.rvalid), 32'd0);
        chk("arst_empty", 32'(bus.empty), 32'd1);
        set_in(1'b0, 1'b0, 1'b0, 8'h00);
        rst_n = 1'b1;
        tick();

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end
endmodule

// File: doc/fifo_ctrl.md
Name: fifo_ctrl

Overview:
- Synchronous FIFO controller for the single-clock FIFO storage array.
- Drives the array's write/read enables and extended write/read pointers. Each pointer is address plus one wrap bit.
- Arbitrates push/pop requests against occupancy, and produces full/empty, almost flags, occupancy count, read-data-valid and sticky error flags for the ALU datapath.

Parameters:
- MEMORY_DEPTH, 4, number of FIFO entries. Must be a power of two and at least 2.
- FIFO_ADDRESS_SIZE, $clog2(MEMORY_DEPTH), address width. Pointers are FIFO_ADDRESS_SIZE+1 bits.
- AFULL_THRESH, MEMORY_DEPTH-1, almost_full asserts when count >= this value.
- AEMPTY_THRESH, 1, almost_empty asserts when count <= this value.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- wr_req  in  1  push request; data presented to the array alongside it
- rd_req  in  1  pop request
- clr_err  in  1  synchronous clear of overflow/underflow
- cw_en  out  1  write enable to the storage array
- cr_en  out  1  read enable to the array's registered read port
- w_ptr  out  FIFO_ADDRESS_SIZE+1  write pointer; MSB is the wrap bit
- r_ptr  out  FIFO_ADDRESS_SIZE+1  read pointer; MSB is the wrap bit
- count  out  FIFO_ADDRESS_SIZE+1  occupancy, 0..MEMORY_DEPTH
- full  out  1  count == MEMORY_DEPTH
- empty  out  1  count == 0
- almost_full  out  1  count >= AFULL_THRESH
- almost_empty  out  1  count <= AEMPTY_THRESH
- rvalid  out  1  array rdata holds the popped word this cycle
- overflow  out  1  sticky; set by a push attempted while full
- underflow  out  1  sticky; set by a pop attempted while empty

Behaviour:
- Reset (async assert, rst_n=0): w_ptr=0, r_ptr=0, count=0, rvalid=0, overflow=0, underflow=0.
  - Derived outputs during reset: empty=1, full=0, almost_empty=1, almost_full=0 (with default thresholds), cw_en=0, cr_en=0.
  - Deassertion is synchronous to clk at the array level; the first accepted request is on the first rising edge with rst_n=1.
- Accept logic (combinational, from registered state):
  - cw_en = wr_req & ~full.
  - cr_en = rd_req & ~empty.
  - Rejected requests are dropped, not queued.
- Pointer update on rising edge:
  - w_ptr += 1 when cw_en; r_ptr += 1 when cr_en.
  - Modulo 2^(FIFO_ADDRESS_SIZE+1); the wrap bit toggles each time the address field passes MEMORY_DEPTH-1.
- Flags (combinational from pointers):
  - empty when w_ptr == r_ptr.
  - full when the MSBs differ and the address fields are equal.
- count:
  - Registered: +1 on push only, -1 on pop only, unchanged on both or neither.
  - Must always equal w_ptr - r_ptr (width FIFO_ADDRESS_SIZE+1). The bench checks this invariant every cycle.
- Simultaneous wr_req & rd_req:
  - Neither full nor empty: both accepted, count unchanged.
  - Full: pop accepted, push rejected, overflow sets.
  - Empty: push accepted, pop rejected, underflow sets. No write-through; the new word is readable from the next cycle.
- Read latency:
  - The array registers read data on the edge where cr_en=1.
  - rvalid <= cr_en (registered), so rvalid is high in exactly the cycle after each accepted pop.
  - Back-to-back pops give back-to-back rvalid.
- Errors:
  - overflow <= 1 on any edge with wr_req & full.
  - underflow <= 1 on any edge with rd_req & empty.
  - clr_err clears both. A set in the same cycle as clr_err wins.
  - Errors never block further operation.
- Reset mid-operation: all state returns to reset values immediately. Array contents are left untouched but are logically discarded.
- No FSM beyond pointer/count state. Design is fully synchronous apart from the async reset.

Test Plan:
- Reset, then 4 pushes with no pops -> count 1,2,3,4; full=1 after the 4th edge; almost_full=1 from count=3; w_ptr=3'b100; r_ptr=0.
- Full FIFO, wr_req=1 for one cycle -> cw_en=0; w_ptr unchanged; overflow=1 and stays 1 until clr_err; clr_err pulse -> overflow=0.
- Fill with 0xA,0xB,0xC,0xD, then 4 pops -> rvalid high one cycle after each cr_en; rdata 0xA..0xD in order; empty=1 and r_ptr=3'b100 at the end.
- Empty FIFO, wr_req=rd_req=1 -> push accepted, pop rejected, underflow=1, count=1. Next cycle wr_req=rd_req=1 -> both accepted, count stays 1.
- Full FIFO, wr_req=rd_req=1 -> pop accepted, push rejected, count=3, overflow=1.
- Wrap test: 10 push/pop pairs interleaved with random stalls -> pointers wrap past 3'b111 to 3'b000; data order preserved; count==w_ptr-r_ptr every cycle.
- With count=2, assert rst_n=0 between clock edges -> count, pointers and rvalid clear asynchronously; empty=1 before the next edge.
